x74ls148_irq_encoder: RTL
=========================

// Module: x74ls148_irq_encoder
// PURPOSE
//  Registered 8-to-3 priority encoder with request latching and a valid/ack handshake.
//  It is the encode direction of the x74ls138 3-to-8 decoder: 8 request lines in, 3-bit index out.
//  It sits between peripheral request lines and a controller that services one request at a time.
//  The code it emits can drive an x74ls138 directly to produce a one-hot acknowledge.
// PARAMETERS
//  N_REQ     8  number of request lines; fixed at 8, present for package consistency
//  CODE_W    3  code width; CODE_W = log2(N_REQ)
//  EDGE_MODE 1  1: a rising edge of req sets pending; 0: req high (level) sets pending
// PORTS
//  clk       in   1       single clock; all state updates on its rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  ON        in   1       enable; 0 = block disabled (decided: this name and polarity)
//  req       in   N_REQ   request lines; synchronous to clk; bit 7 has highest priority
//  mask      in   N_REQ   1 = bit is excluded from selection; it still latches as pending
//  ack       in   1       controller accepts the presented code
//  valid     out  1       code is valid and held stable
//  code      out  CODE_W  index of the selected request
//  gs        out  1       group select: at least one unmasked pending bit and ON = 1
//  pending   out  N_REQ   pending-request register, visible for debug
// BEHAVIOUR
//  Reset (asynchronous, rst_n = 0):
//   - valid = 0, code = 0, gs = 0, pending = 0
//   - req_q = 0 and state = IDLE
//   - In EDGE_MODE=1, a req held high through reset release counts as an edge.
//  Capture (every cycle while ON = 1):
//   - EDGE_MODE=1: set_vec = req & ~req_q.  EDGE_MODE=0: set_vec = req.
//   - Then pending <= (pending & ~clr_vec) | set_vec.
//   - If a bit is both set and cleared in the same cycle, set wins and the bit stays pending.
//  Candidates: cand = pending & ~mask.  gs is the registered value of |cand.
//  FSM states: IDLE, PRESENT.
//   - IDLE: if |cand, then code <= index of the highest set bit of cand, valid <= 1, go to PRESENT.
//   - PRESENT: code is frozen. No preemption: a higher-priority arrival waits.
//   - PRESENT, on valid & ack: clr_vec = onehot(code), valid <= 0, go to IDLE.
//   - ack while in IDLE is ignored.
//   - After an ack, at least one IDLE cycle precedes the next valid.
//   - Masking the presented bit while in PRESENT does not withdraw it.
//  Latency: req rises and is sampled at edge n -> pending set at edge n -> valid = 1 after edge n+1.
//  ON = 0:
//   - Synchronous flush: pending <= 0, valid <= 0, code <= 0, gs <= 0, go to IDLE.
//   - req_q keeps tracking req, so no false edge appears when ON returns to 1.
//   - Dropping ON during PRESENT aborts the presentation with no clear handshake.
//  code is an unsigned 3-bit value with no wrap-around.
//  All 8 bits pending: they are served in order 7, 6, ..., 0, one per handshake.
// STRUCTURE
//  Package x74ls_pkg holds:
//   - localparams N_REQ = 8 and CODE_W = 3
//   - typedef enum logic {IDLE, PRESENT} enc_state_t
//   - function onehot8(code) returning an 8-bit vector
//  Sub-module prio_enc8 (combinational):
//   - input vec[7:0]; outputs idx[2:0] and any
//   - highest set index wins; idx = 0 when vec = 0
//  The top level holds only the capture register, req_q, the FSM and the output registers.
// TESTING
//  1. Reset release with req=0 -> valid=0, code=0, gs=0, pending=8'h00; ack pulses have no effect.
//  2. req=8'h24 for one cycle, EDGE_MODE=1, no ack -> pending=8'h24 and valid=1 with code=5 held;
//     ack -> code=2 two cycles later; second ack -> pending=0 and valid=0.
//  3. In PRESENT with code=2, assert req bit 7 -> code stays 2 until ack, then code=7;
//     repeat with mask=8'h80 -> bit 7 pending but never presented and gs=0.
//  4. Ack of code=3 in the same cycle as a new rising edge on req[3] -> pending[3] stays 1 and code=3
//     is presented again.
//  5. ON=0 during PRESENT with pending=8'hFF -> next cycle valid=0, pending=0, state IDLE;
//     ON=1 with req still high -> no new edge and no valid (EDGE_MODE=1).
//  6. rst_n asserted mid-PRESENT, asynchronously -> all outputs 0 immediately, before the next clk edge;
//     EDGE_MODE=0 with req=8'h01 held -> code=0 re-presented after each ack.

Source files
------------

// File: rtl/x74ls_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | x74ls_pkg : shared sizes, FSM state type and one-hot helper        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package x74ls_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [CODE_W-1:0] code);
    onehot8 = 8'b0000_0001 << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_enc8 : combinational 8-to-3 priority encoder, bit 7 highest   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module prio_enc8
  import x74ls_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Ascending scan so the highest set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        idx = CODE_W'(i);
      end
    end
  end

  assign any = |vec;

endmodule
`default_nettype wire

// File: rtl/x74ls148_irq_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | x74ls148_irq_encoder : registered priority encoder with request    |
// | latching and valid/ack handshake.                      Rev 1.0     |
// +--------------------------------------------------------------------+
module x74ls148_irq_encoder
  import x74ls_pkg::*;
#(
  parameter int EDGE_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ON,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  mask,
  input  logic              ack,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic              gs,
  output logic [N_REQ-1:0]  pending
);

  enc_state_t        r_state;
  enc_state_t        w_state_nxt;
  logic [N_REQ-1:0]  r_req_q;
  logic [N_REQ-1:0]  r_pending;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_gs;

  logic [N_REQ-1:0]  w_set_vec;
  logic [N_REQ-1:0]  w_clr_vec;
  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_pending_nxt;
  logic [CODE_W-1:0] w_idx;
  logic              w_any;
  logic              w_valid_nxt;
  logic [CODE_W-1:0] w_code_nxt;

  assign w_set_vec = (EDGE_MODE != 0) ? (req & ~r_req_q) : req;
  assign w_cand    = r_pending & ~mask;

  prio_enc8 u_prio (
    .vec (w_cand),
    .idx (w_idx),
    .any (w_any)
  );

  // Set is OR-ed after the clear so a simultaneous re-request survives the ack.
  assign w_pending_nxt = ON ? ((r_pending & ~w_clr_vec) | w_set_vec) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    w_clr_vec   = '0;
    if (!ON) begin
      w_state_nxt = IDLE;
      w_valid_nxt = 1'b0;
      w_code_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_code_nxt  = w_idx;
            w_valid_nxt = 1'b1;
            w_state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          // Code stays frozen until ack; no preemption, masking does not withdraw.
          if (r_valid && ack) begin
            w_clr_vec   = onehot8(r_code);
            w_valid_nxt = 1'b0;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // req_q tracks req even while disabled so re-enabling creates no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q <= '0;
    end else begin
      r_req_q <= req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_code    <= '0;
      r_gs      <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_valid   <= w_valid_nxt;
      r_code    <= w_code_nxt;
      r_gs      <= ON & w_any;
    end
  end

  assign valid   = r_valid;
  assign code    = r_code;
  assign gs      = r_gs;
  assign pending = r_pending;

endmodule
`default_nettype wire
